// File: rtl/ray_dir_gen_pkg.sv
// Shared constants, types and Q8.8 helpers for the camera-X ROM, ray generator and raycaster.
package ray_dir_gen_pkg;

  localparam int unsigned SCREEN_W = 320;
  localparam int unsigned Q_W      = 16;
  localparam int unsigned Q_FRAC   = 8;
  localparam int unsigned COL_W    = 9;
  localparam int unsigned PROD_W   = 2 * Q_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic [COL_W-1:0] col;
    logic [Q_W-1:0]   dir_x;
    logic [Q_W-1:0]   dir_y;
  } ray_beat_t;

  // Signed Q8.8 add, clamped to [0x8000, 0x7FFF]
  function automatic logic [Q_W-1:0] sat_add_q88(input logic [Q_W-1:0] a,
                                                 input logic [Q_W-1:0] b);
    logic [Q_W:0] sum;
    sum = {a[Q_W-1], a} + {b[Q_W-1], b};
    if (sum[Q_W] != sum[Q_W-1])
      return sum[Q_W] ? {1'b1, {(Q_W-1){1'b0}}} : {1'b0, {(Q_W-1){1'b1}}};
    return sum[Q_W-1:0];
  endfunction

endpackage

// File: rtl/ray_fifo.sv
// First-word-fall-through FIFO with occupancy count; DEPTH must be a power of two.
module ray_fifo #(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign w_pop  = i_pop && (r_count != '0);
  assign w_push = i_push && ((r_count != CW'(DEPTH)) || w_pop);

  // Storage and write pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
      r_wr_ptr        <= r_wr_ptr + AW'(1);
    end
  end

  // Read pointer and occupancy; push+pop together leaves the count unchanged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/ray_dir_gen.sv
// Per-frame ray direction generator: sweeps columns, reads camera-X, emits dir + plane*cameraX.
module ray_dir_gen
  import ray_dir_gen_pkg::*;
#(
  parameter int unsigned SCREEN_W   = ray_dir_gen_pkg::SCREEN_W,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [Q_W-1:0]   dir_x,
  input  logic [Q_W-1:0]   dir_y,
  input  logic [Q_W-1:0]   plane_x,
  input  logic [Q_W-1:0]   plane_y,
  output logic [COL_W-1:0] rom_addr,
  input  logic [Q_W-1:0]   rom_camerax,
  output logic             ray_valid,
  input  logic             ray_ready,
  output logic [COL_W-1:0] ray_col,
  output logic [Q_W-1:0]   ray_dir_x,
  output logic [Q_W-1:0]   ray_dir_y,
  output logic             busy,
  output logic             done
);

  localparam int unsigned      CNT_W    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(SCREEN_W - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_accept;
  logic             w_issue;
  logic             w_done_set;
  logic [COL_W-1:0] r_col;
  logic [Q_W-1:0]   r_dir_x;
  logic [Q_W-1:0]   r_dir_y;
  logic [Q_W-1:0]   r_plane_x;
  logic [Q_W-1:0]   r_plane_y;
  logic             r_s1_vld;
  logic [COL_W-1:0] r_s1_col;
  logic             r_s2_vld;
  logic [COL_W-1:0] r_s2_col;
  logic [PROD_W-1:0] r_s2_px;
  logic [PROD_W-1:0] r_s2_py;
  logic [PROD_W-1:0] w_px;
  logic [PROD_W-1:0] w_py;
  logic             r_busy;
  logic             r_done;
  logic [CNT_W-1:0] w_fifo_count;
  logic             w_fifo_empty;
  logic             w_credit_ok;
  logic             w_pop;
  logic             w_last_pop;
  ray_beat_t        w_push_beat;
  ray_beat_t        w_head;
  logic             w_unused;

  // Credits: columns in the pipeline plus buffered beats must leave room in the FIFO
  assign w_credit_ok = (CNT_W'(r_s1_vld) + CNT_W'(r_s2_vld) + w_fifo_count) < CNT_W'(FIFO_DEPTH);
  assign w_pop       = ray_valid && ray_ready;
  assign w_last_pop  = w_pop && (w_head.col == LAST_COL);

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_state_nxt = ST_ISSUE;
      ST_ISSUE: if (w_credit_ok && (r_col == LAST_COL)) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (w_last_pop) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM control strobes
  always_comb begin
    w_accept   = 1'b0;
    w_issue    = 1'b0;
    w_done_set = 1'b0;
    case (r_state)
      ST_IDLE:  w_accept   = start;
      ST_ISSUE: w_issue    = w_credit_ok;
      ST_DRAIN: w_done_set = w_last_pop;
      default:  ;
    endcase
  end

  // Frame control: column counter, latched vectors, busy/done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col     <= '0;
      r_dir_x   <= '0;
      r_dir_y   <= '0;
      r_plane_x <= '0;
      r_plane_y <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= w_done_set;
      if (w_accept) begin
        r_col     <= '0;
        r_dir_x   <= dir_x;
        r_dir_y   <= dir_y;
        r_plane_x <= plane_x;
        r_plane_y <= plane_y;
        r_busy    <= 1'b1;
      end else begin
        if (w_issue && (r_col != LAST_COL)) r_col <= r_col + COL_W'(1);
        if (w_done_set) r_busy <= 1'b0;
      end
    end
  end

  // Sign-extended 16x16 products; only the low 32 bits are kept
  assign w_px = $signed({{Q_W{r_plane_x[Q_W-1]}}, r_plane_x}) *
                $signed({{Q_W{rom_camerax[Q_W-1]}}, rom_camerax});
  assign w_py = $signed({{Q_W{r_plane_y[Q_W-1]}}, r_plane_y}) *
                $signed({{Q_W{rom_camerax[Q_W-1]}}, rom_camerax});

  // S1 (ROM data + multiply) and S2 (product) pipeline registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_vld <= 1'b0;
      r_s1_col <= '0;
      r_s2_vld <= 1'b0;
      r_s2_col <= '0;
      r_s2_px  <= '0;
      r_s2_py  <= '0;
    end else begin
      r_s1_vld <= w_issue;
      r_s1_col <= r_col;
      r_s2_vld <= r_s1_vld;
      r_s2_col <= r_s1_col;
      r_s2_px  <= w_px;
      r_s2_py  <= w_py;
    end
  end

  // S2: truncate Q16.16 product to Q8.8 and saturate-add the direction
  always_comb begin
    w_push_beat       = '0;
    w_push_beat.col   = r_s2_col;
    w_push_beat.dir_x = sat_add_q88(r_dir_x, r_s2_px[Q_FRAC +: Q_W]);
    w_push_beat.dir_y = sat_add_q88(r_dir_y, r_s2_py[Q_FRAC +: Q_W]);
  end

  assign w_unused = ^{r_s2_px[PROD_W-1:Q_FRAC+Q_W], r_s2_px[Q_FRAC-1:0],
                      r_s2_py[PROD_W-1:Q_FRAC+Q_W], r_s2_py[Q_FRAC-1:0]};

  ray_fifo #(
    .WIDTH($bits(ray_beat_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_s2_vld),
    .i_data  (w_push_beat),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  assign rom_addr  = r_col;
  assign ray_valid = !w_fifo_empty;
  assign ray_col   = w_head.col;
  assign ray_dir_x = w_head.dir_x;
  assign ray_dir_y = w_head.dir_y;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_ray_dir_gen.sv
// Self-checking bench for ray_dir_gen: ROM model, beat scoreboard and directed frame scenarios.
module tb_ray_dir_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] dir_x = '0, dir_y = '0, plane_x = '0, plane_y = '0;
  logic [8:0]  rom_addr;
  logic [15:0] rom_camerax = '0;
  logic        ray_valid;
  logic        ray_ready = 1'b0;
  logic [8:0]  ray_col;
  logic [15:0] ray_dir_x, ray_dir_y;
  logic        busy, done;

  int n_checks = 0;
  int n_errors = 0;

  int          rom_mode = 0;
  logic [15:0] m_dx, m_dy, m_px, m_py;
  int          exp_col = 0;
  bit          chk_en = 1'b0;
  int          done_cnt = 0;
  bit          rnd = 1'b0;
  bit          ready_hold = 1'b1;
  bit          p_stall = 1'b0;
  logic [8:0]  p_col;
  logic [15:0] p_dx, p_dy;

  ray_dir_gen dut (
    .clk(clk), .rst(rst), .start(start),
    .dir_x(dir_x), .dir_y(dir_y), .plane_x(plane_x), .plane_y(plane_y),
    .rom_addr(rom_addr), .rom_camerax(rom_camerax),
    .ray_valid(ray_valid), .ray_ready(ray_ready), .ray_col(ray_col),
    .ray_dir_x(ray_dir_x), .ray_dir_y(ray_dir_y),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rom_val(input int c);
    if (rom_mode == 1) return 16'h00FE;
    return 16'((c * 512) / 320 - 256);
  endfunction

  // Golden ray component: dir + floor(plane*cx / 256) wrapped to 16 bits, then clamped
  function automatic logic [15:0] ray_model(input logic [15:0] d, input logic [15:0] p,
                                            input logic [15:0] cx);
    int prod;
    int s;
    logic [15:0] q;
    prod = int'($signed(p)) * int'($signed(cx));
    prod = prod >>> 8;
    q = prod[15:0];
    s = int'($signed(d)) + int'($signed(q));
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return 16'(s);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Synchronous camera-X ROM: data one cycle after address
  always @(posedge clk) rom_camerax <= rom_val(int'(rom_addr));

  // Downstream ready driver
  always @(posedge clk) begin
    #2;
    ray_ready = rnd ? 1'($urandom_range(0, 1)) : ready_hold;
  end

  // Scoreboard: every valid beat must be the next column with model directions
  always @(negedge clk) begin
    if (chk_en) begin
      logic [15:0] cx;
      if (done) done_cnt++;
      if (p_stall) begin
        chk("hold_valid", 32'(ray_valid), 32'(1));
        chk("hold_col", 32'(ray_col), 32'(p_col));
        chk("hold_dx", 32'(ray_dir_x), 32'(p_dx));
        chk("hold_dy", 32'(ray_dir_y), 32'(p_dy));
      end
      if (ray_valid) begin
        cx = rom_val(exp_col);
        chk("beat_col", 32'(ray_col), 32'(exp_col));
        chk("beat_dx", 32'(ray_dir_x), 32'(ray_model(m_dx, m_px, cx)));
        chk("beat_dy", 32'(ray_dir_y), 32'(ray_model(m_dy, m_py, cx)));
        if (ray_ready) exp_col++;
      end
      p_stall = ray_valid && !ray_ready;
      p_col   = ray_col;
      p_dx    = ray_dir_x;
      p_dy    = ray_dir_y;
    end
  end

  // Pulse start; returns in cycle 1 of the frame (posedge + 1)
  task automatic frame_start(input logic [15:0] dx, input logic [15:0] dy,
                             input logic [15:0] px, input logic [15:0] py);
    m_dx = dx; m_dy = dy; m_px = px; m_py = py;
    dir_x = dx; dir_y = dy; plane_x = px; plane_y = py;
    exp_col  = 0;
    done_cnt = 0;
    p_stall  = 1'b0;
    chk_en   = 1'b1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    if (!done) begin
      n_checks++;
      n_errors++;
      $display("FAIL done_timeout: got no done after %0d cycles", n);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("done_count", 32'(done_cnt), 32'(1));
    chk("beats", 32'(exp_col), 32'(320));
    chk("busy_after", 32'(busy), 32'(0));
  endtask

  task automatic wait_cond_col(input int col);
    int n = 0;
    while (!(ray_valid && int'(ray_col) == col) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 3000) begin
      n_checks++;
      n_errors++;
      $display("FAIL wait_col: got no beat for column %0d", col);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    int first_v;

    // Reset values
    #1;
    chk("rst_rom_addr", 32'(rom_addr), 32'(0));
    chk("rst_valid", 32'(ray_valid), 32'(0));
    chk("rst_col", 32'(ray_col), 32'(0));
    chk("rst_dx", 32'(ray_dir_x), 32'(0));
    chk("rst_dy", 32'(ray_dir_y), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    // Nominal frame with ready high
    ready_hold = 1'b1;
    frame_start(16'hFF00, 16'h0000, 16'h0000, 16'h00A9);
    chk("c1_busy", 32'(busy), 32'(1));
    chk("c1_rom_addr", 32'(rom_addr), 32'(0));
    n = 1;
    first_v = -1;
    while (!done && n < 1000) begin
      if (ray_valid && first_v < 0) first_v = n;
      if (ray_valid && ray_col == 9'd0) begin
        chk("col0_dx", 32'(ray_dir_x), 32'(16'hFF00));
        chk("col0_dy", 32'(ray_dir_y), 32'(16'hFF57));
      end
      if (ray_valid && ray_col == 9'd160) begin
        chk("col160_dx", 32'(ray_dir_x), 32'(16'hFF00));
        chk("col160_dy", 32'(ray_dir_y), 32'(16'h0000));
      end
      @(posedge clk); #1;
      n++;
    end
    chk("first_valid_cycle", 32'(first_v), 32'(4));
    chk("done_cycle", 32'(n), 32'(324));
    repeat (3) @(posedge clk);
    #1;
    chk("nom_done_count", 32'(done_cnt), 32'(1));
    chk("nom_beats", 32'(exp_col), 32'(320));
    chk("nom_busy_after", 32'(busy), 32'(0));
    chk("nom_valid_after", 32'(ray_valid), 32'(0));

    // Backpressure: 50-cycle stall mid-frame
    frame_start(16'hFF00, 16'h0000, 16'h0000, 16'h00A9);
    n = 0;
    while (exp_col < 100 && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    ready_hold = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    chk("stall_valid", 32'(ray_valid), 32'(1));
    chk("stall_rom_addr", 32'(rom_addr), 32'(exp_col + 4));
    ready_hold = 1'b1;
    wait_done();

    // Random ready with an ignored start pulse mid-frame
    rnd = 1'b1;
    frame_start(16'hFF00, 16'h0000, 16'h0000, 16'h00A9);
    repeat (100) @(posedge clk);
    #1;
    dir_x = 16'h1234; dir_y = 16'h4321; plane_x = 16'h0100; plane_y = 16'h0200;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("restart_ignored_busy", 32'(busy), 32'(1));
    wait_done();
    rnd = 1'b0;

    // Saturation: both components clamp
    rom_mode = 1;
    frame_start(16'h7F00, 16'h8100, 16'h7F00, 16'h8100);
    wait_cond_col(0);
    chk("sat_pos", 32'(ray_dir_x), 32'(16'h7FFF));
    chk("sat_neg", 32'(ray_dir_y), 32'(16'h8000));
    wait_done();
    rom_mode = 0;

    // Reset mid-sweep at column 100, then a clean restart
    frame_start(16'hFF00, 16'h0000, 16'h0000, 16'h00A9);
    wait_cond_col(100);
    chk_en = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_valid", 32'(ray_valid), 32'(0));
    chk("midrst_busy", 32'(busy), 32'(0));
    chk("midrst_rom_addr", 32'(rom_addr), 32'(0));
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_no_done", 32'(done), 32'(0));
    frame_start(16'hFF00, 16'h0000, 16'h0000, 16'h00A9);
    wait_cond_col(0);
    chk("restart_first_col", 32'(ray_col), 32'(0));
    chk("restart_first_dy", 32'(ray_dir_y), 32'(16'hFF57));
    wait_done();

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
